// File: rtl/press_classifier.sv
// Multi-channel push-button press classifier for the front panel.
// Each channel synchronises, debounces and classifies presses as short or long.
module press_classifier #(
    parameter int N_CH            = 4,
    parameter int DEBOUNCE_P      = 300,
    parameter int LONG_T          = 5000,
    parameter int LONG_ON_RELEASE = 1,
    parameter int CNT_W           = $clog2(LONG_T + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] push_button,
    output logic [N_CH-1:0] short_o,
    output logic [N_CH-1:0] long_o,
    output logic [N_CH-1:0] hold_o,
    output logic            any_evt_o
);

    typedef enum logic [2:0] {
        IDLE,
        DB_PRESS,
        HELD,
        LONG_HELD,
        DB_RELEASE
    } state_t;

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_P - 1);
    localparam logic [CNT_W-1:0] DB_DONE = CNT_W'(DEBOUNCE_P);
    localparam logic [CNT_W-1:0] LT_LAST = CNT_W'(LONG_T - 1);

    logic [N_CH-1:0] short_d;
    logic [N_CH-1:0] long_d;
    logic [N_CH-1:0] hold_d;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [1:0]       sync;
        logic             s;
        state_t           state, state_nx;
        logic [CNT_W-1:0] press_cnt, press_nx;
        logic [CNT_W-1:0] rel_cnt, rel_nx;
        logic             kind, kind_nx;
        logic             entry;
        logic             done;

        assign s = sync[1];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                sync      <= '0;
                state     <= IDLE;
                press_cnt <= '0;
                rel_cnt   <= '0;
                kind      <= 1'b0;
                entry     <= 1'b0;
            end else begin
                sync      <= {sync[0], push_button[i]};
                state     <= state_nx;
                press_cnt <= press_nx;
                rel_cnt   <= rel_nx;
                kind      <= kind_nx;
                // one-cycle marker for the first cycle spent in LONG_HELD
                entry     <= (state == HELD) && s && (press_cnt == LT_LAST);
            end
        end

        always_comb begin
            state_nx = state;
            press_nx = press_cnt;
            rel_nx   = rel_cnt;
            kind_nx  = kind;
            unique case (state)
                IDLE: begin
                    press_nx = '0;
                    rel_nx   = '0;
                    if (s) begin
                        state_nx = DB_PRESS;
                        press_nx = ONE;
                    end
                end
                DB_PRESS: begin
                    if (!s) begin
                        state_nx = IDLE;
                        press_nx = '0;
                    end else begin
                        press_nx = press_cnt + ONE;
                        if (press_cnt == DB_LAST) state_nx = HELD;
                    end
                end
                HELD: begin
                    if (!s) begin
                        state_nx = DB_RELEASE;
                        kind_nx  = 1'b0;
                        rel_nx   = ONE;
                    end else begin
                        press_nx = press_cnt + ONE;
                        if (press_cnt == LT_LAST) state_nx = LONG_HELD;
                    end
                end
                LONG_HELD: begin
                    if (!s) begin
                        state_nx = DB_RELEASE;
                        kind_nx  = 1'b1;
                        rel_nx   = ONE;
                    end
                end
                DB_RELEASE: begin
                    if (s) begin
                        state_nx = kind ? LONG_HELD : HELD;
                        rel_nx   = '0;
                    end else if (rel_cnt == DB_DONE) begin
                        state_nx = IDLE;
                        rel_nx   = '0;
                        press_nx = '0;
                    end else begin
                        rel_nx = rel_cnt + ONE;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    press_nx = '0;
                    rel_nx   = '0;
                end
            endcase
        end

        assign done = (state == DB_RELEASE) && !s && (rel_cnt == DB_DONE);

        always_comb begin
            short_d[i] = done && !kind;
            long_d[i]  = (LONG_ON_RELEASE != 0) ? (done && kind) : entry;
            hold_d[i]  = (state == LONG_HELD)
                      || ((state == DB_RELEASE) && kind && !done);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            short_o   <= '0;
            long_o    <= '0;
            hold_o    <= '0;
            any_evt_o <= 1'b0;
        end else begin
            short_o   <= short_d;
            long_o    <= long_d;
            hold_o    <= hold_d;
            any_evt_o <= |(short_d | long_d);
        end
    end

endmodule

// File: tb/tb_press_classifier.sv
// Bench for press_classifier: two instances (long on release / long on threshold)
// share one button bus; expected outputs come from a per-cycle event schedule.
module tb_press_classifier;

    localparam int P    = 4;
    localparam int LT   = 20;
    localparam int MAXC = 8192;

    logic       clk;
    logic       rst;
    logic [1:0] pb;
    logic [1:0] s1, l1, h1;
    logic [1:0] s0, l0, h0;
    logic       a1, a0;

    logic [1:0] ex_s  [MAXC];
    logic [1:0] ex_l1 [MAXC];
    logic [1:0] ex_l0 [MAXC];
    logic [1:0] ex_h  [MAXC];

    int cyc;
    int total;
    int passed;

    press_classifier #(
        .N_CH(2), .DEBOUNCE_P(P), .LONG_T(LT), .LONG_ON_RELEASE(1)
    ) dut1 (
        .clk(clk), .rst(rst), .push_button(pb),
        .short_o(s1), .long_o(l1), .hold_o(h1), .any_evt_o(a1)
    );

    press_classifier #(
        .N_CH(2), .DEBOUNCE_P(P), .LONG_T(LT), .LONG_ON_RELEASE(0)
    ) dut0 (
        .clk(clk), .rst(rst), .push_button(pb),
        .short_o(s0), .long_o(l0), .hold_o(h0), .any_evt_o(a0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] obs,
                       input logic [1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s cyc=%0d observed=%b expected=%b",
                    tag, cyc, obs, exp);
    endtask

    // A press whose raw level rises after edge k0 and falls after edge krel;
    // extra = synchronised samples that did not add to the press length.
    task automatic sched(input int ch, input int k0, input int krel,
                         input int extra);
        int eff, pc, ls;
        eff = krel - k0 - extra;
        pc  = krel + P + 3;
        ls  = k0 + LT + 3 + extra;
        if (eff >= P && pc < MAXC) begin
            if (eff < LT) begin
                ex_s[pc][ch] = 1'b1;
            end else begin
                ex_l1[pc][ch] = 1'b1;
                ex_l0[ls][ch] = 1'b1;
                for (int c = ls; c < pc; c++) ex_h[c][ch] = 1'b1;
            end
        end
    endtask

    task automatic step();
        logic [1:0] es, e1, e0, eh;
        @(posedge clk);
        #1;
        cyc++;
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC);
            $fatal(1, "cycle budget exceeded");
        end
        es = ex_s[cyc];
        e1 = ex_l1[cyc];
        e0 = ex_l0[cyc];
        eh = ex_h[cyc];
        chk("short_r", s1, es);
        chk("long_r", l1, e1);
        chk("hold_r", h1, eh);
        chk("any_r", {1'b0, a1}, {1'b0, |(es | e1)});
        chk("short_t", s0, es);
        chk("long_t", l0, e0);
        chk("hold_t", h0, eh);
        chk("any_t", {1'b0, a0}, {1'b0, |(es | e0)});
        @(negedge clk);
    endtask

    task automatic press2(input int len0, input int len1, input int gap);
        int k0, m;
        k0 = cyc;
        if (len0 > 0) sched(0, k0, k0 + len0, 0);
        if (len1 > 0) sched(1, k0, k0 + len1, 0);
        m = (len0 > len1) ? len0 : len1;
        for (int t = 0; t < m + gap; t++) begin
            pb[0] = (t < len0);
            pb[1] = (t < len1);
            step();
        end
        pb = 2'b00;
    endtask

    function automatic int pick_len();
        int r;
        r = int'($urandom_range(0, 3));
        if (r == 0) return 0;
        if (r == 1) return int'($urandom_range(1, P - 1));
        if (r == 2) return int'($urandom_range(P, LT - 1));
        return int'($urandom_range(LT, 50));
    endfunction

    initial begin
        int k0;
        cyc    = 0;
        total  = 0;
        passed = 0;
        for (int c = 0; c < MAXC; c++) begin
            ex_s[c]  = 2'b00;
            ex_l1[c] = 2'b00;
            ex_l0[c] = 2'b00;
            ex_h[c]  = 2'b00;
        end
        pb  = 2'b00;
        rst = 1'b1;
        #2 rst = 1'b0;
        for (int i = 0; i < 3; i++) step();
        rst = 1'b1;
        step();

        // glitch shorter than the debounce window
        press2(3, 0, 12);
        // short press, event 7 cycles after raw release
        press2(10, 0, 15);
        // long press on channel 1
        press2(0, 40, 15);
        // threshold boundary
        press2(19, 0, 15);
        press2(20, 0, 15);
        press2(0, LT - 1, 15);
        press2(0, LT, 15);

        // release bounce inside HELD
        k0 = cyc;
        sched(0, k0, k0 + 42, 3);
        for (int t = 0; t < 57; t++) begin
            pb[0] = (t < 10) || (t >= 12 && t < 42);
            pb[1] = 1'b0;
            step();
        end
        pb = 2'b00;

        // simultaneous long presses
        press2(30, 30, 15);
        // very long press still yields one event
        press2(200, 0, 15);

        // reset in the middle of a press discards it
        for (int t = 0; t < 15; t++) begin
            pb = 2'b11;
            step();
        end
        rst = 1'b0;
        pb  = 2'b00;
        for (int i = 0; i < 3; i++) step();
        rst = 1'b1;
        for (int i = 0; i < 40; i++) step();

        // randomised independent presses on both channels
        for (int n = 0; n < 30; n++) begin
            press2(pick_len(), pick_len(), int'($urandom_range(P + 5, 16)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/press_classifier.md
# press_classifier

Multi-channel, parametrised push-button press classifier for the lighting controller's front panel. Each of `N_CH` raw button inputs is synchronised and debounced on both press and release, then classified as a short press or a long press. Each channel emits one-cycle event pulses and a long-hold level. An aggregated "any event" strobe serves the mode-control logic downstream.

## Interface
- `N_CH`, default 4: number of independent button channels (≥1).
- `DEBOUNCE_P`, default 300: consecutive stable cycles required to accept a press or a release (≥2).
- `LONG_T`, default 5000: press-duration threshold in cycles for a long press (> `DEBOUNCE_P`).
- `LONG_ON_RELEASE`, default 1: 1 = `long_o` fires on debounced release; 0 = `long_o` fires when `LONG_T` is reached while still held.
- `CNT_W`, default $clog2(`LONG_T`+1): press counter width (derived; not overridden).

- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `push_button`  in  `N_CH`  raw, asynchronous button levels; 1 = pressed.
- `short_o`  out  `N_CH`  one-cycle pulse per channel: short press completed.
- `long_o`  out  `N_CH`  one-cycle pulse per channel: long press (timing per `LONG_ON_RELEASE`).
- `hold_o`  out  `N_CH`  level per channel: high while the channel is in `LONG_HELD` or in its release debounce.
- `any_evt_o`  out  1  OR of all `short_o` and `long_o` bits, same cycle.

## Operation
- Per channel: 2-FF synchroniser; `s` = synchronised level. All channels are identical and fully independent.
- FSM states per channel: `IDLE`, `DB_PRESS`, `HELD`, `LONG_HELD`, `DB_RELEASE`.
- `IDLE`: `press_cnt`=0. On `s`=1, go to `DB_PRESS` with `press_cnt`=1.
- `DB_PRESS`:
  - `s`=0: go to `IDLE`. No event (glitch).
  - `s`=1: `press_cnt`++. When `press_cnt` = `DEBOUNCE_P`, go to `HELD`.
- `HELD`:
  - `s`=1: `press_cnt`++. When `press_cnt` = `LONG_T`, go to `LONG_HELD`.
  - `s`=0: go to `DB_RELEASE` with `kind`=short, `rel_cnt`=1.
- `LONG_HELD`:
  - `press_cnt` saturates at `LONG_T`. No wrap.
  - On entry, if `LONG_ON_RELEASE`=0, pulse `long_o` once.
  - `s`=0: go to `DB_RELEASE` with `kind`=long, `rel_cnt`=1.
- `DB_RELEASE`:
  - `press_cnt` is frozen.
  - `s`=0: `rel_cnt`++. When `rel_cnt` = `DEBOUNCE_P`, go to `IDLE`. Then pulse `short_o` if `kind`=short; pulse `long_o` if `kind`=long and `LONG_ON_RELEASE`=1. `kind`=long with `LONG_ON_RELEASE`=0 emits nothing.
  - `s`=1 before completion: release glitch. Return to `HELD` or `LONG_HELD` per `kind`; `rel_cnt` cleared, no event. A `HELD` return resumes counting from the frozen `press_cnt`.
- `hold_o` is high in `LONG_HELD` and in `DB_RELEASE` with `kind`=long.
- A channel never emits more than one event per press. `short_o` and `long_o` are never both high on one channel.
- Simultaneous events on several channels each pulse their own bit; `any_evt_o` is a single-cycle high.

## Timing
- Reset (`rst`=0, asynchronous):
  - All FSMs to `IDLE`; counters and synchronisers cleared.
  - `short_o`, `long_o`, `hold_o`, `any_evt_o` = 0, held for the whole time `rst` is low.
- Reset mid-press discards the press. No event is emitted after reset release until a fresh press is seen.
- All outputs are registered, with no combinational path from `push_button` to any output.
- Latency:
  - Synchroniser adds 2 cycles.
  - Press accepted `DEBOUNCE_P` cycles after `s` rises.
  - Release pulse appears in the cycle after `rel_cnt` reaches `DEBOUNCE_P`, i.e. `DEBOUNCE_P`+3 cycles after a raw falling edge held stable.
- Pulse width is exactly 1 cycle.
- `LONG_ON_RELEASE`=0: `long_o` appears the cycle after `press_cnt` reaches `LONG_T`.
- `hold_o` rises the cycle after entry into `LONG_HELD` and falls with the release pulse cycle.
- Boundaries:
  - A press lasting exactly `LONG_T`-1 counted cycles is short.
  - A press lasting exactly `LONG_T` counted cycles is long.
  - A press held far beyond `LONG_T` (e.g. 10×) still yields exactly one `long_o`.

## Test plan
All scenarios use `N_CH`=2, `DEBOUNCE_P`=4, `LONG_T`=20, `LONG_ON_RELEASE`=1 unless stated.
- Reset and glitch: hold `rst`=0 for 3 cycles → all outputs 0. Then press ch0 for 3 cycles → no pulse, ch0 returns to `IDLE`.
- Short press: press ch0 for 10 cycles, release → exactly one `short_o[0]` and `any_evt_o` pulse, 7 cycles after the raw release. `long_o`=0 and `hold_o`=0 throughout.
- Long press: press ch1 for 40 cycles, release → `hold_o[1]` high from the cycle after `LONG_HELD` entry, then one `long_o[1]` pulse with `hold_o[1]` falling in that cycle.
- Threshold boundary: hold for `press_cnt` = 19 → `short_o`; hold for `press_cnt` = 20 → `long_o`.
- Release bounce: in `HELD`, drop input for 2 cycles, re-press for 30 cycles, then release → no event at the bounce; one `long_o` at the end.
- `LONG_ON_RELEASE`=0: hold ch0 and ch1 simultaneously for 30 cycles → both `long_o` bits pulse in the same cycle with one `any_evt_o`, and no further pulse on release. Assert `rst`=0 mid-hold on a second press → outputs 0 and no event afterward.
